datapath: RTL and testbench

- 32-bit single-bus CPU datapath: 16 general registers R0–R15, plus PC, IR, MAR, MDR, HI, LO, Y and a 64-bit Z (Zhigh:Zlow).
- Includes a combinational ALU.
- An external control unit or testbench sequences it with one-hot register-in/register-out strobes, one microstep per clock.
- Memory data enters through the MDR.

---
 rtl/datapath.sv | 234 +++++++++++++++++++++++
 tb/tb_datapath.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath -- 32-bit single-bus CPU datapath
//
// Purpose:
//   A classic single-bus datapath: sixteen general registers R0-R15 plus
//   PC, IR, MAR, MDR, HI, LO, Y and a 64-bit Z register (Zhigh:Zlow),
//   with a combinational ALU. An external control unit sequences it one
//   microstep per clock with one-hot register-in / register-out strobes.
//   Memory read data enters through the MDR.
//
// Configuration:
//   `define DATAPATH_MULDIV_EN  enables the signed multiplier (ALUop 11)
//                               and signed divider (ALUop 12). When left
//                               undefined, both ops return 0 and no
//                               multiplier/divider hardware is built.
//
// Ports:
//   clock              rising-edge clock
//   clear              asynchronous active-high reset of every register
//   A                  external value placed on the bus when nothing drives it
//   RegisterImmediate  immediate operand for ADDI
//   Read               MDR input select: 1 = Mdatain, 0 = bus
//   Mdatain            memory read data
//   ALUop              ALU operation select
//   Rin / Rout         per-register load enables / bus-source selects
//   MARin..LOin        single register load enables
//   PCout, MDRout,
//   Zlowout            bus-source selects
//   Zhighin, Zlowin    load Z[63:32] / Z[31:0] from the ALU result
//   MARout..Zhighout   continuous register contents
// ---------------------------------------------------------------------------
module datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] RegisterImmediate,
  input  logic             Read,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [3:0]       ALUop,
  input  logic [NREGS-1:0] Rin,
  input  logic [NREGS-1:0] Rout,
  input  logic             MARin,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             MDRin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             PCout,
  input  logic             MDRout,
  input  logic             Zlowout,
  input  logic             Zhighin,
  input  logic             Zlowin,
  output logic [WIDTH-1:0] MARout,
  output logic [WIDTH-1:0] IRout,
  output logic [WIDTH-1:0] Yout,
  output logic [WIDTH-1:0] HIout,
  output logic [WIDTH-1:0] LOout,
  output logic [WIDTH-1:0] Zhighout
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHRA = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_NEG  = 4'd9,
    OP_NOT  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12,
    OP_ADDI = 4'd13,
    OP_INC  = 4'd14,
    OP_PASS = 4'd15
  } alu_op_t;

  logic [WIDTH-1:0]   gpr [NREGS];
  logic [WIDTH-1:0]   pc;
  logic [WIDTH-1:0]   ir;
  logic [WIDTH-1:0]   mar;
  logic [WIDTH-1:0]   mdr;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   zhigh;
  logic [WIDTH-1:0]   zlow;

  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [4:0]         shamt;
  logic [2*WIDTH-1:0] doubled;
  alu_op_t            op;

  assign MARout   = mar;
  assign IRout    = ir;
  assign Yout     = y;
  assign HIout    = hi;
  assign LOout    = lo;
  assign Zhighout = zhigh;

  assign op_a    = y;
  assign op_b    = bus;
  assign shamt   = op_b[4:0];
  assign doubled = {op_a, op_a};
  assign op      = alu_op_t'(ALUop);

  // Bus source selection. Sources are applied from lowest to highest
  // priority so that the last assignment wins: Zlow, then MDR, then PC,
  // then the general registers scanned downward so the lowest index wins.
  // With no source selected the external A input drives the bus.
  always_comb begin
    bus = A;
    if (Zlowout) bus = zlow;
    if (MDRout)  bus = mdr;
    if (PCout)   bus = pc;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (Rout[i]) bus = gpr[i];
    end
  end

`ifdef DATAPATH_MULDIV_EN
  logic [2*WIDTH-1:0]      product;
  logic signed [WIDTH-1:0] quotient;
  logic signed [WIDTH-1:0] remainder;

  // Signed multiply and divide. Operands are sign-extended to 64 bits so
  // an unsigned 64-bit product equals the signed product. A zero divisor
  // would make the quotient undefined, so it is replaced by all-ones with
  // the dividend passed through as the remainder.
  always_comb begin
    product   = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
    quotient  = '1;
    remainder = $signed(op_a);
    if (op_b != '0) begin
      quotient  = $signed(op_a) / $signed(op_b);
      remainder = $signed(op_a) % $signed(op_b);
    end
  end
`endif

  // ALU. Only MUL and DIV produce a non-zero upper half. Rotates take a
  // window out of the operand concatenated with itself, which makes a
  // rotate by zero fall out naturally as the operand unchanged.
  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result[WIDTH-1:0] = op_a + op_b;
      OP_SUB:  result[WIDTH-1:0] = op_a - op_b;
      OP_AND:  result[WIDTH-1:0] = op_a & op_b;
      OP_OR:   result[WIDTH-1:0] = op_a | op_b;
      OP_SHR:  result[WIDTH-1:0] = op_a >> shamt;
      OP_SHL:  result[WIDTH-1:0] = op_a << shamt;
      OP_SHRA: result[WIDTH-1:0] = $signed(op_a) >>> shamt;
      OP_ROR:  result[WIDTH-1:0] = WIDTH'(doubled >> shamt);
      OP_ROL:  result[WIDTH-1:0] = doubled[2*WIDTH-1:WIDTH] << shamt
                                   | doubled[WIDTH-1:0] >> (6'(WIDTH) - {1'b0, shamt});
      OP_NEG:  result[WIDTH-1:0] = '0 - op_b;
      OP_NOT:  result[WIDTH-1:0] = ~op_b;
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:  result = product;
      OP_DIV:  result = {remainder, quotient};
`else
      OP_MUL:  result = '0;
      OP_DIV:  result = '0;
`endif
      OP_ADDI: result[WIDTH-1:0] = op_a + RegisterImmediate;
      OP_INC:  result[WIDTH-1:0] = op_b + 1'b1;
      OP_PASS: result[WIDTH-1:0] = op_b;
      default: result = '0;
    endcase
  end

  // General register file. Each register loads from the bus on its own
  // enable; a register that is also driving the bus simply reloads itself.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (Rin[i]) gpr[i] <= bus;
      end
    end
  end

  // Special-purpose registers that load straight from the bus.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      hi  <= '0;
      lo  <= '0;
      y   <= '0;
    end else begin
      if (PCin)  pc  <= bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (HIin)  hi  <= bus;
      if (LOin)  lo  <= bus;
      if (Yin)   y   <= bus;
    end
  end

  // MDR takes either memory read data or the bus, chosen by Read.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mdr <= '0;
    end else if (MDRin) begin
      mdr <= Read ? Mdatain : bus;
    end
  end

  // The two halves of Z capture the ALU result independently so a
  // microstep can keep one half while updating the other.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      zhigh <= '0;
      zlow  <= '0;
    end else begin
      if (Zhighin) zhigh <= result[2*WIDTH-1:WIDTH];
      if (Zlowin)  zlow  <= result[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] A;
   logic [31:0] RegisterImmediate;
   logic        Read;
   logic [31:0] Mdatain;
   logic [3:0]  ALUop;
   logic [15:0] Rin;
   logic [15:0] Rout;
   logic        MARin, PCin, IRin, Yin, MDRin, HIin, LOin;
   logic        PCout, MDRout, Zlowout, Zhighin, Zlowin;
   logic [31:0] MARout, IRout, Yout, HIout, LOout, Zhighout;

   int checksTotal  = 0;
   int checksPassed = 0;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [31:0] expLow;
      logic [31:0] expHigh;
   } aluVec_t;

   aluVec_t     vecs[$];
   logic [31:0] regModel[16];

   datapath dut (
      .clock(clock), .clear(clear), .A(A), .RegisterImmediate(RegisterImmediate),
      .Read(Read), .Mdatain(Mdatain), .ALUop(ALUop), .Rin(Rin), .Rout(Rout),
      .MARin(MARin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .MDRin(MDRin),
      .HIin(HIin), .LOin(LOin), .PCout(PCout), .MDRout(MDRout),
      .Zlowout(Zlowout), .Zhighin(Zhighin), .Zlowin(Zlowin),
      .MARout(MARout), .IRout(IRout), .Yout(Yout), .HIout(HIout),
      .LOout(LOout), .Zhighout(Zhighout)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Reference ALU written from the operation definitions: shifts and
   // rotates move one bit at a time, multiply/divide use 64-bit integers.
   function automatic logic [63:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm);
      logic [31:0] r;
      longint      sa, sb, p, q, m;
      int          s;
      r  = a;
      s  = int'(b[4:0]);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd0:  return {32'd0, a + b};
         4'd1:  return {32'd0, a - b};
         4'd2:  return {32'd0, a & b};
         4'd3:  return {32'd0, a | b};
         4'd4:  begin for (int k = 0; k < s; k++) r = {1'b0, r[31:1]}; return {32'd0, r}; end
         4'd5:  begin for (int k = 0; k < s; k++) r = {r[30:0], 1'b0}; return {32'd0, r}; end
         4'd6:  begin for (int k = 0; k < s; k++) r = {r[31], r[31:1]}; return {32'd0, r}; end
         4'd7:  begin for (int k = 0; k < s; k++) r = {r[0], r[31:1]}; return {32'd0, r}; end
         4'd8:  begin for (int k = 0; k < s; k++) r = {r[30:0], r[31]}; return {32'd0, r}; end
         4'd9:  return {32'd0, 32'd0 - b};
         4'd10: return {32'd0, ~b};
`ifdef DATAPATH_MULDIV_EN
         4'd11: begin p = sa * sb; return p; end
         4'd12: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            m = sa % sb;
            return {m[31:0], q[31:0]};
         end
`else
         4'd11: return 64'd0;
         4'd12: return 64'd0;
`endif
         4'd13: return {32'd0, a + imm};
         4'd14: return {32'd0, b + 32'd1};
         default: return {32'd0, b};
      endcase
   endfunction

   // Single comparison with pass/fail bookkeeping.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checksTotal++;
      if (actual === expected) checksPassed++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Drop every strobe back to idle.
   task automatic idle();
      Read = 1'b0; ALUop = 4'd0; Rin = '0; Rout = '0;
      MARin = 1'b0; PCin = 1'b0; IRin = 1'b0; Yin = 1'b0; MDRin = 1'b0;
      HIin = 1'b0; LOin = 1'b0; PCout = 1'b0; MDRout = 1'b0; Zlowout = 1'b0;
      Zhighin = 1'b0; Zlowin = 1'b0;
   endtask

   // One microstep: clock the currently driven strobes, then idle them.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic writeReg(input int idx, input logic [31:0] val);
      A = val; Rin = 16'b1 << idx;
      applyStimulus();
   endtask

   // Copy a register onto MAR so its value becomes observable.
   task automatic checkReg(input string name, input int idx, input logic [31:0] expected);
      Rout = 16'b1 << idx; MARin = 1'b1;
      applyStimulus();
      checkOutput(name, MARout, expected);
   endtask

   // Y <- a, Z <- ALU(Y, b), then Zlow is routed to MAR for observation.
   task automatic runAlu(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] expLow, input logic [31:0] expHigh);
      A = a; Yin = 1'b1;
      applyStimulus();
      A = b; ALUop = op; RegisterImmediate = imm; Zlowin = 1'b1; Zhighin = 1'b1;
      applyStimulus();
      checkOutput({name, "_hi"}, Zhighout, expHigh);
      Zlowout = 1'b1; MARin = 1'b1;
      applyStimulus();
      checkOutput({name, "_lo"}, MARout, expLow);
   endtask

   task automatic addVec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] expLow, input logic [31:0] expHigh);
      aluVec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.imm = imm;
      v.expLow = expLow; v.expHigh = expHigh;
      vecs.push_back(v);
   endtask

   initial begin
      logic [63:0] exp64;
      logic [31:0] ra, rb, ri;
      logic [3:0]  rop;
      int          idx;

      idle();
      A = '0; Mdatain = '0; RegisterImmediate = '0;
      clear = 1'b1;

      // Power-on reset state
      #1;
      checkOutput("rst_mar", MARout, 32'd0);
      checkOutput("rst_ir", IRout, 32'd0);
      checkOutput("rst_y", Yout, 32'd0);
      checkOutput("rst_hi", HIout, 32'd0);
      checkOutput("rst_lo", LOout, 32'd0);
      checkOutput("rst_zhigh", Zhighout, 32'd0);
      @(negedge clock);
      clear = 1'b0;
      @(posedge clock);
      #1;

      // Mid-run asynchronous clear
      writeReg(3, 32'h1234);
      A = 32'h1111; HIin = 1'b1; LOin = 1'b1; Yin = 1'b1; MARin = 1'b1; IRin = 1'b1; PCin = 1'b1;
      applyStimulus();
      checkOutput("load_hi", HIout, 32'h1111);
      checkOutput("load_ir", IRout, 32'h1111);
      #2;
      clear = 1'b1;
      #1;
      checkOutput("aclr_mar", MARout, 32'd0);
      checkOutput("aclr_ir", IRout, 32'd0);
      checkOutput("aclr_y", Yout, 32'd0);
      checkOutput("aclr_hi", HIout, 32'd0);
      checkOutput("aclr_lo", LOout, 32'd0);
      clear = 1'b0;
      checkReg("aclr_r3", 3, 32'd0);
      PCout = 1'b1; MARin = 1'b1;
      applyStimulus();
      checkOutput("aclr_pc", MARout, 32'd0);

      // Clear wins over a simultaneous load
      clear = 1'b1; A = 32'h99; MARin = 1'b1; Rin = 16'b10;
      applyStimulus();
      clear = 1'b0;
      checkOutput("clrwin_mar", MARout, 32'd0);
      checkReg("clrwin_r1", 1, 32'd0);

      // SHRA microprogram through MDR
      Read = 1'b1; Mdatain = 32'hFFFFFFF0; MDRin = 1'b1; applyStimulus();
      MDRout = 1'b1; Rin = 16'b1; applyStimulus();
      Read = 1'b1; Mdatain = 32'h00000002; MDRin = 1'b1; applyStimulus();
      MDRout = 1'b1; Rin = 16'b1 << 4; applyStimulus();
      Rout = 16'b1; Yin = 1'b1; applyStimulus();
      Rout = 16'b1 << 4; ALUop = 4'd6; Zlowin = 1'b1; applyStimulus();
      Zlowout = 1'b1; Rin = 16'b1 << 7; applyStimulus();
      checkReg("shra_r7", 7, 32'hFFFFFFFC);
      checkOutput("shra_y", Yout, 32'hFFFFFFF0);

      // Instruction fetch
      A = 32'h10; PCin = 1'b1; applyStimulus();
      PCout = 1'b1; MARin = 1'b1; ALUop = 4'd14; Zlowin = 1'b1; applyStimulus();
      checkOutput("fetch_mar", MARout, 32'h10);
      Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'hABCD0000; applyStimulus();
      MDRout = 1'b1; IRin = 1'b1; applyStimulus();
      checkOutput("fetch_ir", IRout, 32'hABCD0000);
      PCout = 1'b1; MARin = 1'b1; applyStimulus();
      checkOutput("fetch_pc", MARout, 32'h11);

      // Bus priority and default source
      writeReg(2, 32'hAAAA);
      A = 32'hBBBB; PCin = 1'b1; applyStimulus();
      Rout = 16'b100; PCout = 1'b1; MARin = 1'b1; applyStimulus();
      checkOutput("prio_r2_over_pc", MARout, 32'hAAAA);
      Rout = 16'b1100; MARin = 1'b1; applyStimulus();
      checkOutput("prio_low_index", MARout, 32'hAAAA);
      PCout = 1'b1; MDRout = 1'b1; Zlowout = 1'b1; MARin = 1'b1; applyStimulus();
      checkOutput("prio_pc_over_mdr", MARout, 32'hBBBB);
      MDRout = 1'b1; Zlowout = 1'b1; MARin = 1'b1; applyStimulus();
      checkOutput("prio_mdr_over_z", MARout, 32'hABCD0000);
      A = 32'h55; Rin = 16'b1 << 9; applyStimulus();
      checkReg("default_a_r9", 9, 32'h55);

      // Load while sourcing keeps the value
      writeReg(5, 32'hCAFE0005);
      A = 32'h0; Rout = 16'b1 << 5; Rin = 16'b1 << 5; applyStimulus();
      checkReg("self_load_r5", 5, 32'hCAFE0005);

      // Table-driven ALU vectors
      addVec("add", 4'd0, 32'd5, 32'd7, 32'd0, 32'd12, 32'd0);
      addVec("add_wrap", 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0);
      addVec("sub", 4'd1, 32'd3, 32'd5, 32'd0, 32'hFFFFFFFE, 32'd0);
      addVec("and", 4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'hF000F000, 32'd0);
      addVec("or", 4'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0, 32'hFFFFFFFF, 32'd0);
      addVec("shr", 4'd4, 32'h80000001, 32'd1, 32'd0, 32'h40000000, 32'd0);
      addVec("shl", 4'd5, 32'h80000001, 32'd1, 32'd0, 32'h00000002, 32'd0);
      addVec("ror", 4'd7, 32'h80000001, 32'd1, 32'd0, 32'hC0000000, 32'd0);
      addVec("rol", 4'd8, 32'h80000001, 32'd1, 32'd0, 32'h00000003, 32'd0);
      addVec("shr_32", 4'd4, 32'h80000001, 32'd32, 32'd0, 32'h80000001, 32'd0);
      addVec("rol_32", 4'd8, 32'h80000001, 32'd32, 32'd0, 32'h80000001, 32'd0);
      addVec("shra", 4'd6, 32'h80000000, 32'd4, 32'd0, 32'hF8000000, 32'd0);
      addVec("neg", 4'd9, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0);
      addVec("not", 4'd10, 32'd0, 32'h0000FFFF, 32'd0, 32'hFFFF0000, 32'd0);
      addVec("addi", 4'd13, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd4, 32'd0);
      addVec("inc", 4'd14, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0);
      addVec("pass", 4'd15, 32'd9, 32'h12345678, 32'd0, 32'h12345678, 32'd0);
`ifdef DATAPATH_MULDIV_EN
      addVec("mul", 4'd11, 32'hFFFFFFFE, 32'd3, 32'd0, 32'hFFFFFFFA, 32'hFFFFFFFF);
      addVec("div", 4'd12, 32'd7, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFD, 32'd1);
      addVec("div0", 4'd12, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd7);
`else
      addVec("mul_off", 4'd11, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 32'd0);
      addVec("div_off", 4'd12, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd0);
`endif
      for (int i = 0; i < vecs.size(); i++) begin
         runAlu(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm,
                vecs[i].expLow, vecs[i].expHigh);
      end

      // Randomized ALU operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         ri  = $urandom;
         if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
         exp64 = refAlu(rop, ra, rb, ri);
         runAlu($sformatf("rnd_alu%0d_op%0d", i, rop), rop, ra, rb, ri, exp64[31:0], exp64[63:32]);
      end

      // Randomized register-file writes and reads against an array model
      clear = 1'b1;
      #1;
      clear = 1'b0;
      for (int i = 0; i < 16; i++) regModel[i] = 32'd0;
      for (int i = 0; i < 40; i++) begin
         idx = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) begin
            ra = $urandom;
            writeReg(idx, ra);
            regModel[idx] = ra;
         end else begin
            checkReg($sformatf("rnd_reg%0d_r%0d", i, idx), idx, regModel[idx]);
         end
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
